// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the multi-channel PIO bank: per-channel register map and
// parameter limits.
package soc_system_pio_pkg;

  localparam int unsigned REG_BITS = 3;

  localparam logic [REG_BITS-1:0] REG_DATA_OUT = 3'd0;
  localparam logic [REG_BITS-1:0] REG_DATA_IN  = 3'd1;
  localparam logic [REG_BITS-1:0] REG_OUT_SET  = 3'd2;
  localparam logic [REG_BITS-1:0] REG_OUT_CLR  = 3'd3;
  localparam logic [REG_BITS-1:0] REG_IRQ_MASK = 3'd4;
  localparam logic [REG_BITS-1:0] REG_EDGE_CAP = 3'd5;
  localparam logic [REG_BITS-1:0] REG_EDGE_SEL = 3'd6;
  localparam logic [REG_BITS-1:0] REG_RSVD     = 3'd7;

  localparam int unsigned MAX_WIDTH    = 32;
  localparam int unsigned MAX_CHANNELS = 8;

endpackage

// File: rtl/soc_system_pio_channel.sv
// One PIO channel: output register with set/clear, input synchroniser, edge capture
// and the masked pending flag feeding the bank interrupt.
module soc_system_pio_channel
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [REG_BITS-1:0] reg_sel,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [WIDTH-1:0]    in_port,
  output logic [WIDTH-1:0]    out_port,
  output logic [WIDTH-1:0]    rdata,
  output logic                pending
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] edge_det;

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    sel_d  = sel_q;
    w1c    = '0;
    if (wr_en) begin
      unique case (reg_sel)
        REG_DATA_OUT: out_d  = wdata;
        REG_OUT_SET:  out_d  = out_q | wdata;
        REG_OUT_CLR:  out_d  = out_q & ~wdata;
        REG_IRQ_MASK: mask_d = wdata;
        REG_EDGE_CAP: w1c    = wdata;
        REG_EDGE_SEL: sel_d  = wdata;
        default:      ;
      endcase
    end
    edge_det = (sync2_q & ~prev_q & ~sel_q) | (~sync2_q & prev_q & sel_q);
    // A fresh edge wins over a simultaneous write-1-to-clear.
    cap_d    = (cap_q & ~w1c) | edge_det;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= OUT_RESET;
      mask_q  <= '0;
      cap_q   <= '0;
      sel_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      out_q   <= out_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      sel_q   <= sel_d;
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      REG_DATA_OUT: rdata = out_q;
      REG_DATA_IN:  rdata = sync2_q;
      REG_IRQ_MASK: rdata = mask_q;
      REG_EDGE_CAP: rdata = cap_q;
      REG_EDGE_SEL: rdata = sel_q;
      default:      rdata = '0;
    endcase
  end

  assign out_port = out_q;
  assign pending  = |(cap_q & mask_q);

endmodule

// File: rtl/soc_system_pio_bank.sv
// Avalon-MM slave wrapping CHANNELS PIO channels: address decode, registered read
// data (latency 1) and the combined registered interrupt.
module soc_system_pio_bank
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      CHANNELS  = 4,
  parameter logic [WIDTH-1:0] OUT_RESET = '0,
  localparam int unsigned     AW        = $clog2(CHANNELS) + REG_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AW-1:0]             address,
  input  logic                      chipselect,
  input  logic                      read_n,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [CHANNELS*WIDTH-1:0] out_port,
  input  logic [CHANNELS*WIDTH-1:0] in_port,
  output logic                      irq
);

  logic                wr, rd;
  int unsigned         ch_idx;
  logic [REG_BITS-1:0] reg_sel;
  logic [CHANNELS-1:0] wr_en;
  logic [CHANNELS-1:0] pending;
  logic [WIDTH-1:0]    ch_rdata [CHANNELS];
  logic [31:0]         rd_word;
  logic [31:0]         readdata_q;
  logic                irq_q;
  logic                unused_wd;

  assign wr      = chipselect & ~write_n;
  assign rd      = chipselect & ~read_n;
  assign ch_idx  = 32'(address) >> REG_BITS;
  assign reg_sel = address[REG_BITS-1:0];
  assign unused_wd = ^(writedata >> WIDTH);

  // Out-of-range channel indices match no channel: writes drop, reads return 0.
  always_comb begin
    wr_en   = '0;
    rd_word = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      wr_en[c] = wr && (ch_idx == c);
      if (ch_idx == c) rd_word[WIDTH-1:0] = ch_rdata[c];
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    soc_system_pio_channel #(
      .WIDTH     (WIDTH),
      .OUT_RESET (OUT_RESET)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en[c]),
      .reg_sel  (reg_sel),
      .wdata    (writedata[WIDTH-1:0]),
      .in_port  (in_port[c*WIDTH +: WIDTH]),
      .out_port (out_port[c*WIDTH +: WIDTH]),
      .rdata    (ch_rdata[c]),
      .pending  (pending[c])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (rd) readdata_q <= rd_word;
      irq_q <= |pending;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_soc_system_pio_bank.sv
// Self-checking bench for soc_system_pio_bank (WIDTH=8, CHANNELS=3, OUT_RESET=0x05)
// against a register-level behavioural model.
module tb_soc_system_pio_bank;

  localparam int unsigned W  = 8;
  localparam int unsigned CH = 3;
  localparam int unsigned AW = 5;
  localparam logic [W-1:0] RST_VAL = 8'h05;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   address;
  logic            chipselect, read_n, write_n;
  logic [31:0]     writedata, readdata;
  logic [CH*W-1:0] out_port, in_port;
  logic            irq;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] out_m [CH];
  logic [W-1:0] mask_m[CH];
  logic [W-1:0] cap_m [CH];
  logic [W-1:0] sel_m [CH];
  logic [W-1:0] in_m  [CH];

  soc_system_pio_bank #(
    .WIDTH     (W),
    .CHANNELS  (CH),
    .OUT_RESET (RST_VAL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      out_m[c] = RST_VAL; mask_m[c] = '0; cap_m[c] = '0; sel_m[c] = '0; in_m[c] = '0;
    end
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d);
    int unsigned c = 32'(a) >> 3;
    int unsigned r = 32'(a) & 7;
    logic [W-1:0] v = d[W-1:0];
    if (c >= CH) return;
    case (r)
      0: out_m[c] = v;
      2: out_m[c] = out_m[c] | v;
      3: out_m[c] = out_m[c] & ~v;
      4: mask_m[c] = v;
      5: cap_m[c] = cap_m[c] & ~v;
      6: sel_m[c] = v;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    int unsigned c = 32'(a) >> 3;
    int unsigned r = 32'(a) & 7;
    if (c >= CH) return 32'h0;
    case (r)
      0: return 32'(out_m[c]);
      1: return 32'(in_m[c]);
      4: return 32'(mask_m[c]);
      5: return 32'(cap_m[c]);
      6: return 32'(sel_m[c]);
      default: return 32'h0;
    endcase
  endfunction

  // A settled input change is captured where the bit moved in the selected direction.
  task automatic model_in(input logic [CH*W-1:0] v);
    for (int c = 0; c < CH; c++) begin
      for (int b = 0; b < W; b++) begin
        logic o, n;
        o = in_m[c][b];
        n = v[c*W+b];
        if (o != n && (sel_m[c][b] ? !n : n)) cap_m[c][b] = 1'b1;
      end
      in_m[c] = v[c*W +: W];
    end
  endtask

  function automatic logic [CH*W-1:0] model_out();
    logic [CH*W-1:0] v;
    for (int c = 0; c < CH; c++) v[c*W +: W] = out_m[c];
    return v;
  endfunction

  function automatic logic model_irq();
    logic i = 1'b0;
    for (int c = 0; c < CH; c++) i |= |(cap_m[c] & mask_m[c]);
    return i;
  endfunction

  // ---------------- bus drivers ----------------
  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    model_write(a, d);
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    d = readdata;
  endtask

  task automatic set_in(input logic [CH*W-1:0] v);
    @(negedge clk);
    in_port = v;
    model_in(v);
    repeat (5) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; in_port = '0;
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; address = '0; writedata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if (out_port !== {CH{RST_VAL}}) begin
      bad++; $display("FAIL reset_out: got %h want %h", out_port, {CH{RST_VAL}});
    end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    total++;
    if (readdata !== 32'h0) begin
      bad++; $display("FAIL reset_readdata: got %h want 0", readdata);
    end
    reset = 1'b0;
    bus_read(5'd16, d);
    total++;
    if (d !== 32'h5) begin bad++; $display("FAIL reset_read_ch2: got %h want 5", d); end
  endtask

  task automatic test_set_clear();
    bus_write(5'd8, 32'h0000F0F0);
    bus_write(5'd10, 32'h0000000F);
    bus_write(5'd11, 32'h000000F0);
    total++;
    if (out_port[W +: W] !== 8'h0F) begin
      bad++; $display("FAIL set_clear_ch1: got %h want 0f", out_port[W +: W]);
    end
    total++;
    if (out_port !== model_out()) begin
      bad++; $display("FAIL set_clear_all: got %h want %h", out_port, model_out());
    end
  endtask

  task automatic test_edge_capture();
    logic [CH*W-1:0] v;
    v = in_port; v[7:0] = 8'h02;
    set_in(v);
    bus_write(5'd5, 32'hFF);
    bus_write(5'd6, 32'h2);
    bus_write(5'd4, 32'h3);
    // Hold a read of EDGE_CAP ch0 while bit0 rises and bit1 falls before edge N.
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; address = 5'd5;
    v[7:0] = 8'h01; in_port = v;
    repeat (3) @(negedge clk);
    total++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      bad++; $display("FAIL edge_n2: got cap=%h irq=%b want cap=0 irq=0", readdata, irq);
    end
    model_in(v);
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    total++;
    if (readdata !== model_read(5'd5)) begin
      bad++; $display("FAIL edge_cap_n3: got %h want %h", readdata, model_read(5'd5));
    end
    total++;
    if (irq !== model_irq()) begin
      bad++; $display("FAIL edge_irq_n3: got %b want %b", irq, model_irq());
    end
    bus_write(5'd5, 32'h1);
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL w1c_bit0_irq: got %b want 1", irq); end
    bus_write(5'd5, 32'h2);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL w1c_lag_irq: got %b want 1", irq); end
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL w1c_last_irq: got %b want 0", irq); end
  endtask

  task automatic test_collision();
    logic [CH*W-1:0] v;
    logic [31:0] d;
    v = in_port; v[7:0] = 8'h00;
    set_in(v);
    bus_write(5'd5, 32'hFF);
    @(negedge clk);
    v[7:0] = 8'h01; in_port = v;
    repeat (2) @(negedge clk);
    // W1C strobe sampled on the same edge that captures bit0.
    chipselect = 1'b1; write_n = 1'b0; address = 5'd5; writedata = 32'h1;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    model_write(5'd5, 32'h1);
    model_in(v);
    repeat (2) @(negedge clk);
    bus_read(5'd5, d);
    total++;
    if (d[0] !== 1'b1 || d !== model_read(5'd5)) begin
      bad++; $display("FAIL collision_cap: got %h want %h", d, model_read(5'd5));
    end
    total++;
    if (irq !== model_irq()) begin
      bad++; $display("FAIL collision_irq: got %b want %b", irq, model_irq());
    end
  endtask

  task automatic test_rw_same_cycle();
    logic [31:0] wd, old;
    wd = $urandom;
    old = model_read(5'd16);
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0; address = 5'd16; writedata = wd;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    model_write(5'd16, wd);
    total++;
    if (readdata !== old) begin
      bad++; $display("FAIL rw_same_read: got %h want %h", readdata, old);
    end
    total++;
    if (out_port !== model_out()) begin
      bad++; $display("FAIL rw_same_out: got %h want %h", out_port, model_out());
    end
  endtask

  task automatic test_width_range();
    logic [31:0] d;
    bus_write(5'd0, 32'hFFFFFFFF);
    bus_read(5'd0, d);
    total++;
    if (d !== 32'h000000FF) begin bad++; $display("FAIL width_mask: got %h want ff", d); end
    bus_write(5'd24, 32'h12);
    total++;
    if (out_port !== model_out()) begin
      bad++; $display("FAIL range_write: got %h want %h", out_port, model_out());
    end
    bus_read(5'd24, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL range_read: got %h want 0", d); end
    bus_read(5'd7, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rsvd_read: got %h want 0", d); end
    bus_read(5'd2, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL wo_read: got %h want 0", d); end
  endtask

  task automatic test_random();
    logic [31:0] d, exp;
    logic [AW-1:0] a;
    for (int i = 0; i < 200; i++) begin
      int unsigned op = $urandom_range(0, 9);
      a = AW'($urandom_range(0, 31));
      if (op <= 5) begin
        bus_write(a, $urandom);
      end else if (op <= 7) begin
        exp = model_read(a);
        bus_read(a, d);
        total++;
        if (d !== exp) begin
          bad++; $display("FAIL rand_read[%0d] addr=%0d: got %h want %h", i, a, d, exp);
        end
      end else if (op == 8) begin
        set_in(CH*W'($urandom));
      end else begin
        @(negedge clk);
      end
      total++;
      if (out_port !== model_out()) begin
        bad++; $display("FAIL rand_out[%0d]: got %h want %h", i, out_port, model_out());
      end
      @(negedge clk);
      total++;
      if (irq !== model_irq()) begin
        bad++; $display("FAIL rand_irq[%0d]: got %b want %b", i, irq, model_irq());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 5'd8; writedata = $urandom;
    #2 reset = 1'b1; in_port = '0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    total++;
    if (readdata !== 32'h0) begin
      bad++; $display("FAIL mid_reset_readdata: got %h want 0", readdata);
    end
    @(negedge clk);
    total++;
    if (out_port[W +: W] !== RST_VAL || out_port !== model_out()) begin
      bad++; $display("FAIL mid_reset_out: got %h want %h", out_port, model_out());
    end
    bus_read(5'd5, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL mid_reset_cap: got %h want 0", d); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL mid_reset_irq: got %b want 0", irq); end
  endtask

  initial begin
    test_reset();
    test_set_clear();
    test_edge_capture();
    test_collision();
    test_rw_same_cycle();
    test_width_range();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
